// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared widths, beat-buffer entry layout and scan FSM states
package sme_pkg;

   localparam int LANES      = 8;
   localparam int LANE_W     = 8;
   localparam int LANE_IDX_W = 3;
   localparam int DATA_W     = LANES * LANE_W;

   typedef struct packed {
      logic [DATA_W-1:0] vec;
      logic              last;
   } beat_entry_t;

   localparam int ENTRY_W = $bits(beat_entry_t);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   function automatic logic [LANE_IDX_W-1:0] lowest_lane(input logic [LANES-1:0] m);
      logic [LANE_IDX_W-1:0] res;
      res = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i]) res = LANE_IDX_W'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; caller guarantees no push when full without pop
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/first_filter_match_reader.sv
// rtl/first_filter_match_reader.sv - buffers filter beats and emits one record per hit byte lane
module first_filter_match_reader
   import sme_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int POS_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic [POS_W-1:0]  out_pos,
   output logic [7:0]        out_vec,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow
);

   localparam int                IDX_W   = POS_W - LANE_IDX_W;
   localparam logic [IDX_W-1:0]  IDX_MAX = '1;

   scan_state_t           state, state_n;
   beat_entry_t           wr_entry, head;
   logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [LANES-1:0]      lane_hit, remaining, cleared;
   logic [IDX_W-1:0]      beat_idx;
   logic [LANE_IDX_W-1:0] lane;
   logic                  step, load_ok, any_hit, final_lane, advance;
   logic                  rec_valid, rec_last;
   logic [POS_W-1:0]      rec_pos;
   logic [LANE_W-1:0]     rec_vec;

   // Stored inverted so a set bit means a hit from here on.
   assign wr_entry  = '{vec: ~in_data, last: in_last};
   assign fifo_push = in_valid & (~fifo_full | fifo_pop);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_beat_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (wr_entry),
      .pop   (fifo_pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      state_n = state;
      step    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               step    = 1'b1;
               state_n = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (fifo_empty) state_n = ST_IDLE;
            else            step    = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      lane_hit = '0;
      for (int b = 0; b < LANES; b++) begin
         lane_hit[b] = |head.vec[b*LANE_W +: LANE_W];
      end
      remaining  = lane_hit & ~cleared;
      any_hit    = |remaining;
      lane       = lowest_lane(remaining);
      final_lane = any_hit && ((remaining & (remaining - LANES'(1))) == '0);
      load_ok    = ~out_valid | out_ready;

      // A hitless non-final beat retires without needing the output slot.
      rec_valid  = step & (any_hit | head.last);
      rec_pos    = {beat_idx, (any_hit ? lane : LANE_IDX_W'(LANES - 1))};
      rec_vec    = any_hit ? head.vec[{lane, 3'b000} +: LANE_W] : '0;
      rec_last   = head.last & (~any_hit | final_lane);
      advance    = step & (rec_valid ? load_ok : 1'b1);
      fifo_pop   = advance & (~any_hit | final_lane);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cleared   <= '0;
         beat_idx  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_vec   <= '0;
         out_pos   <= '0;
         overflow  <= 1'b0;
      end else begin
         state <= state_n;
         if (in_valid && fifo_full && !fifo_pop) overflow <= 1'b1;

         if (fifo_pop) begin
            cleared <= '0;
            if (head.last)                beat_idx <= '0;
            else if (beat_idx != IDX_MAX) beat_idx <= beat_idx + IDX_W'(1);
         end else if (advance) begin
            cleared <= cleared | (LANES'(1) << lane);
         end

         if (load_ok) begin
            out_valid <= rec_valid;
            if (rec_valid) begin
               out_pos  <= rec_pos;
               out_vec  <= rec_vec;
               out_last <= rec_last;
            end
         end
      end
   end

endmodule
